reg_state_scheduler: RTL and testbench
======================================

Name: reg_state_scheduler

Overview:
Controller for the per-register state cell array: gates decoded instructions into the runahead queue against register hazard status, and drives the one-hot UsedAsA/UsedAsB/IssuedAsA/IssuedAsB strobes plus WillBeWritingToA/MarkDirty into the cells. Tracks runahead queue occupancy and provides a drain sequence for flush/context switch. Sits between decode and the runahead queue/issue stage.

Parameters:
REG_COUNT, 16, number of architectural registers/state cells
REG_ADDR_W, 4, register address width (log2 REG_COUNT)
QUEUE_DEPTH, 8, runahead queue entries; occupancy counter range 0..QUEUE_DEPTH

Ports:
clk  in  1  clock
clk_en  in  1  global clock enable; no state advances when low
sync_rst  in  1  synchronous active-high reset
dec_valid  in  1  decoded instruction offered
dec_ready  out  1  instruction accepted this cycle (push)
dec_a_addr  in  REG_ADDR_W  A operand register
dec_b_addr  in  REG_ADDR_W  B operand register
dec_writes_a  in  1  instruction writes A
dec_uses_b  in  1  instruction reads B
dec_multicycle  in  1  result arrives via load/multicycle path
cell_dirty  in  REG_COUNT  Dirty per register
cell_to_be_written  in  REG_COUNT  ToBeWritten per register
issue_valid  in  1  queue head issued this cycle
issue_a_addr  in  REG_ADDR_W  issued A register
issue_b_addr  in  REG_ADDR_W  issued B register
issue_uses_b  in  1  issued instruction reads B
used_as_a  out  REG_COUNT  one-hot A strobe on push
used_as_b  out  REG_COUNT  one-hot B strobe on push
will_write_a  out  1  = dec_writes_a on push, else 0
mark_dirty  out  1  = dec_multicycle on push, else 0
issued_as_a  out  REG_COUNT  one-hot A strobe on issue
issued_as_b  out  REG_COUNT  one-hot B strobe on issue
flush_req  in  1  request drain (level)
drained  out  1  queue empty, no dirty registers, intake blocked
occupancy  out  $clog2(QUEUE_DEPTH+1)  current queue count

Behaviour:
- Reset (sync_rst, regardless of clk_en): state RUN, occupancy 0, drained 0; all strobe outputs combinationally 0 while sync_rst high.
- Hazard (combinational): haz = (dec_writes_a & cell_dirty[a]) | (dec_uses_b & cell_dirty[b]) | (dec_writes_a & dec_multicycle & cell_to_be_written[a]).
- dec_ready = clk_en & ~sync_rst & state==RUN & ~haz & (occupancy<QUEUE_DEPTH | issue_valid). Push = dec_valid & dec_ready.
- used_as_a one-hot at dec_a_addr on push; used_as_b one-hot at dec_b_addr on push & dec_uses_b. Zero-latency (same cycle as push).
- issued_as_a/b one-hot on issue_valid & clk_en (b gated by issue_uses_b); issue_valid with occupancy 0 is illegal (assertion), counter does not underflow.
- Occupancy: +1 push only, -1 issue only, unchanged on both or neither; updates only when clk_en.
- FSM: RUN -> STALL when dec_valid & haz & ~flush_req; STALL -> RUN when hazard clears (dec_ready would be 1 next evaluation) or dec_valid drops; RUN/STALL -> DRAIN on flush_req (priority over stall); DRAIN -> DRAINED when occupancy==0 & cell_dirty==0; DRAINED -> RUN when flush_req deasserts. dec_ready=0 in STALL-with-hazard, DRAIN, DRAINED (STALL still pushes the cycle hazard clears via RUN only, i.e. one-cycle bubble).
- drained = 1 only in DRAINED. Issue strobes still pass in DRAIN.
- sync_rst mid-drain returns to RUN with occupancy 0; cells are reset by the same sync_rst.

Optional Feature:
REG_STATE_SCHED_PERF_EN: adds outputs stall_cycles[15:0] and push_count[15:0], saturating counters, cleared by sync_rst; stall_cycles increments each clk_en cycle in STALL. Without macro: ports and counters absent.

Decomposition:
Shared package reg_sched_pkg: state enum (RUN, STALL, DRAIN, DRAINED), REG_ADDR_W/REG_COUNT defaults, one-hot decode function. One sub-module natural: reg_onehot_decode (addr + enable -> REG_COUNT one-hot), instanced four times.

Test Plan:
Push a=3 writes, b=5 read, no dirty -> dec_ready=1, used_as_a=0x0008, used_as_b=0x0020, occupancy 0->1.
cell_dirty[5]=1, dec b=5 -> dec_ready=0, state STALL; clear dirty -> push one cycle later.
Fill to 8 pushes, no issue -> dec_ready=0; same cycle push+issue at full -> accepted, occupancy stays 8.
flush_req with occupancy 2, cell_dirty[7]=1 -> drained after 2 issues and dirty clears; drop flush_req -> RUN next cycle.
clk_en=0 with dec_valid/issue_valid high -> no strobes, occupancy unchanged.
sync_rst during DRAIN with occupancy 4 -> next cycle RUN, occupancy 0, drained 0.

Source files
------------

// File: rtl/reg_sched_pkg.sv
// Shared types and defaults for the register-state scheduler: scheduler state
// encoding, default sizing and a one-hot decode helper.
package reg_sched_pkg;

  localparam int DEF_REG_COUNT   = 16;
  localparam int DEF_REG_ADDR_W  = 4;
  localparam int DEF_QUEUE_DEPTH = 8;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    DRAIN   = 2'd2,
    DRAINED = 2'd3
  } sched_state_e;

  // Returns a one-hot vector at addr when en is set, all zeros otherwise.
  function automatic logic [DEF_REG_COUNT-1:0] onehot_decode(
    input logic [DEF_REG_ADDR_W-1:0] addr,
    input logic                      en
  );
    logic [DEF_REG_COUNT-1:0] vec;
    vec = '0;
    if (en) begin
      vec[addr] = 1'b1;
    end else begin
      vec = '0;
    end
    return vec;
  endfunction

endpackage

// File: rtl/reg_onehot_decode.sv
// Register address to one-hot strobe decoder with enable; used for the
// UsedAs / IssuedAs strobe vectors driven into the state cells.
module reg_onehot_decode
  import reg_sched_pkg::*;
#(
  parameter int N  = DEF_REG_COUNT,
  parameter int AW = DEF_REG_ADDR_W
) (
  input  logic [AW-1:0] addr,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  // Compare against every register index so any N/AW pairing stays in range.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (addr == AW'(i))) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_state_scheduler_chk.sv
// Simulation-only protocol checker for reg_state_scheduler: the issue stage
// must never issue from an empty runahead queue.
module reg_state_scheduler_chk #(
  parameter int OCC_W = 4
) (
  input logic             clk,
  input logic             sync_rst,
  input logic             clk_en,
  input logic             issue_valid,
  input logic [OCC_W-1:0] occupancy
);

  issue_needs_entry: assert property (
    @(posedge clk) disable iff (sync_rst)
      (clk_en && issue_valid) |-> (occupancy != '0)
  ) else $error("issue_valid asserted with empty runahead queue");

endmodule

// File: rtl/reg_state_scheduler.sv
// Hazard-gated intake into the runahead queue with cell strobe generation and
// a flush drain sequence. Optional perf counters: REG_STATE_SCHED_PERF_EN.
module reg_state_scheduler
  import reg_sched_pkg::*;
#(
  parameter int  REG_COUNT   = DEF_REG_COUNT,
  parameter int  REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int  QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  localparam int OCC_W       = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic                  sync_rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [REG_ADDR_W-1:0] dec_a_addr,
  input  logic [REG_ADDR_W-1:0] dec_b_addr,
  input  logic                  dec_writes_a,
  input  logic                  dec_uses_b,
  input  logic                  dec_multicycle,
  input  logic [REG_COUNT-1:0]  cell_dirty,
  input  logic [REG_COUNT-1:0]  cell_to_be_written,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_a_addr,
  input  logic [REG_ADDR_W-1:0] issue_b_addr,
  input  logic                  issue_uses_b,
  output logic [REG_COUNT-1:0]  used_as_a,
  output logic [REG_COUNT-1:0]  used_as_b,
  output logic                  will_write_a,
  output logic                  mark_dirty,
  output logic [REG_COUNT-1:0]  issued_as_a,
  output logic [REG_COUNT-1:0]  issued_as_b,
  input  logic                  flush_req,
  output logic                  drained,
`ifdef REG_STATE_SCHED_PERF_EN
  output logic [15:0]           stall_cycles,
  output logic [15:0]           push_count,
`endif
  output logic [OCC_W-1:0]      occupancy
);

  sched_state_e     state_r;
  logic             drained_r;
  logic [OCC_W-1:0] occ_r;
  logic             haz_s;
  logic             ready_s;
  logic             push_s;
  logic             issue_s;

  // A writer must wait for prior dirty/pending writes; a reader for dirty data.
  always_comb begin
    haz_s = 1'b0;
    haz_s = (dec_writes_a & cell_dirty[dec_a_addr])
          | (dec_uses_b   & cell_dirty[dec_b_addr])
          | (dec_writes_a & dec_multicycle & cell_to_be_written[dec_a_addr]);
  end

  // Intake: accept only in RUN with no hazard and a free slot (or a slot freed by issue).
  always_comb begin
    ready_s = 1'b0;
    if (clk_en && !sync_rst && (state_r == RUN) && !haz_s &&
        ((occ_r < OCC_W'(QUEUE_DEPTH)) || issue_valid)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign push_s       = dec_valid & ready_s;
  assign issue_s      = issue_valid & clk_en & ~sync_rst;
  assign dec_ready    = ready_s;
  assign will_write_a = push_s & dec_writes_a;
  assign mark_dirty   = push_s & dec_multicycle;
  assign occupancy    = occ_r;
  assign drained      = drained_r;

  reg_onehot_decode #(.N(REG_COUNT), .AW(REG_ADDR_W)) u_dec_a (
    .addr(dec_a_addr), .en(push_s), .onehot(used_as_a));
  reg_onehot_decode #(.N(REG_COUNT), .AW(REG_ADDR_W)) u_dec_b (
    .addr(dec_b_addr), .en(push_s & dec_uses_b), .onehot(used_as_b));
  reg_onehot_decode #(.N(REG_COUNT), .AW(REG_ADDR_W)) u_iss_a (
    .addr(issue_a_addr), .en(issue_s), .onehot(issued_as_a));
  reg_onehot_decode #(.N(REG_COUNT), .AW(REG_ADDR_W)) u_iss_b (
    .addr(issue_b_addr), .en(issue_s & issue_uses_b), .onehot(issued_as_b));

  // Queue occupancy; an issue against an empty queue is ignored rather than wrapping.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      occ_r <= '0;
    end else if (clk_en) begin
      if (push_s && !issue_s) begin
        occ_r <= occ_r + OCC_W'(1);
      end else if (issue_s && !push_s && (occ_r != '0)) begin
        occ_r <= occ_r - OCC_W'(1);
      end else begin
        occ_r <= occ_r;
      end
    end
  end

  // Scheduler FSM; flush takes priority over stall, and drained is registered with the state.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_r   <= RUN;
      drained_r <= 1'b0;
    end else if (clk_en) begin
      case (state_r)
        RUN: begin
          if (flush_req) begin
            state_r <= DRAIN;
          end else if (dec_valid && haz_s) begin
            state_r <= STALL;
          end
        end
        STALL: begin
          if (flush_req) begin
            state_r <= DRAIN;
          end else if (!haz_s || !dec_valid) begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if ((occ_r == '0) && (cell_dirty == '0)) begin
            state_r   <= DRAINED;
            drained_r <= 1'b1;
          end
        end
        DRAINED: begin
          if (!flush_req) begin
            state_r   <= RUN;
            drained_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= RUN;
          drained_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef REG_STATE_SCHED_PERF_EN
  logic [15:0] stall_cycles_r;
  logic [15:0] push_count_r;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      stall_cycles_r <= 16'd0;
      push_count_r   <= 16'd0;
    end else if (clk_en) begin
      if ((state_r == STALL) && (stall_cycles_r != 16'hFFFF)) begin
        stall_cycles_r <= stall_cycles_r + 16'd1;
      end
      if (push_s && (push_count_r != 16'hFFFF)) begin
        push_count_r <= push_count_r + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign push_count   = push_count_r;
`endif

endmodule

// File: tb/tb_reg_state_scheduler.sv
// Self-checking bench for reg_state_scheduler: directed test-plan steps then
// randomized traffic checked against a behavioural model.
module tb_reg_state_scheduler;
  localparam int RC = 16;
  localparam int AW = 4;
  localparam int QD = 8;
  localparam int OW = 4;
  localparam int M_RUN = 0, M_STALL = 1, M_DRAIN = 2, M_DRAINED = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clk_en, sync_rst, dec_valid, dec_ready, dec_writes_a, dec_uses_b, dec_multicycle;
  logic [AW-1:0] dec_a_addr, dec_b_addr, issue_a_addr, issue_b_addr;
  logic [RC-1:0] cell_dirty, cell_to_be_written;
  logic issue_valid, issue_uses_b, will_write_a, mark_dirty, flush_req, drained;
  logic [RC-1:0] used_as_a, used_as_b, issued_as_a, issued_as_b;
  logic [OW-1:0] occupancy;
`ifdef REG_STATE_SCHED_PERF_EN
  logic [15:0] stall_cycles, push_count;
  int m_stall, m_pushes;
`endif

  reg_state_scheduler dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_a_addr(dec_a_addr), .dec_b_addr(dec_b_addr),
    .dec_writes_a(dec_writes_a), .dec_uses_b(dec_uses_b), .dec_multicycle(dec_multicycle),
    .cell_dirty(cell_dirty), .cell_to_be_written(cell_to_be_written),
    .issue_valid(issue_valid), .issue_a_addr(issue_a_addr), .issue_b_addr(issue_b_addr),
    .issue_uses_b(issue_uses_b),
    .used_as_a(used_as_a), .used_as_b(used_as_b),
    .will_write_a(will_write_a), .mark_dirty(mark_dirty),
    .issued_as_a(issued_as_a), .issued_as_b(issued_as_b),
    .flush_req(flush_req), .drained(drained),
`ifdef REG_STATE_SCHED_PERF_EN
    .stall_cycles(stall_cycles), .push_count(push_count),
`endif
    .occupancy(occupancy)
  );

  reg_state_scheduler_chk #(.OCC_W(OW)) u_chk (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .issue_valid(issue_valid), .occupancy(occupancy));

  int errors = 0;
  int checks = 0;
  int m_occ, m_mode;
  bit e_haz, e_ready, e_push, e_iss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RC-1:0] bit_at(input int idx, input bit en);
    logic [RC-1:0] v;
    v = en ? (16'h0001 << idx) : 16'h0000;
    return v;
  endfunction

  task automatic eval_model();
    e_haz = (dec_writes_a && cell_dirty[dec_a_addr]) || (dec_uses_b && cell_dirty[dec_b_addr]) ||
            (dec_writes_a && dec_multicycle && cell_to_be_written[dec_a_addr]);
    e_ready = clk_en && !sync_rst && (m_mode == M_RUN) && !e_haz && ((m_occ < QD) || issue_valid);
    e_push  = dec_valid && e_ready;
    e_iss   = issue_valid && clk_en && !sync_rst;
  endtask

  task automatic settle(input string tag);
    #1;
    eval_model();
    chk({tag, ".dec_ready"}, 32'(dec_ready), 32'(e_ready));
    chk({tag, ".used_as_a"}, 32'(used_as_a), 32'(bit_at(int'(dec_a_addr), e_push)));
    chk({tag, ".used_as_b"}, 32'(used_as_b), 32'(bit_at(int'(dec_b_addr), e_push && dec_uses_b)));
    chk({tag, ".will_write_a"}, 32'(will_write_a), 32'(e_push && dec_writes_a));
    chk({tag, ".mark_dirty"}, 32'(mark_dirty), 32'(e_push && dec_multicycle));
    chk({tag, ".issued_as_a"}, 32'(issued_as_a), 32'(bit_at(int'(issue_a_addr), e_iss)));
    chk({tag, ".issued_as_b"}, 32'(issued_as_b), 32'(bit_at(int'(issue_b_addr), e_iss && issue_uses_b)));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(m_occ));
    chk({tag, ".drained"}, 32'(drained), 32'(m_mode == M_DRAINED));
`ifdef REG_STATE_SCHED_PERF_EN
    chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
    chk({tag, ".push_count"}, 32'(push_count), 32'(m_pushes));
`endif
  endtask

  task automatic adv();
    int nxt;
    @(posedge clk);
    if (sync_rst) begin
      m_mode = M_RUN;
      m_occ  = 0;
`ifdef REG_STATE_SCHED_PERF_EN
      m_stall = 0; m_pushes = 0;
`endif
    end else if (clk_en) begin
`ifdef REG_STATE_SCHED_PERF_EN
      if (m_mode == M_STALL && m_stall < 65535) m_stall++;
      if (e_push && m_pushes < 65535) m_pushes++;
`endif
      nxt = m_mode;
      if ((m_mode == M_RUN || m_mode == M_STALL) && flush_req) nxt = M_DRAIN;
      else if (m_mode == M_RUN && dec_valid && e_haz) nxt = M_STALL;
      else if (m_mode == M_STALL && (!e_haz || !dec_valid)) nxt = M_RUN;
      else if (m_mode == M_DRAIN && m_occ == 0 && cell_dirty == '0) nxt = M_DRAINED;
      else if (m_mode == M_DRAINED && !flush_req) nxt = M_RUN;
      m_mode = nxt;
      m_occ  = m_occ + (e_push ? 1 : 0) - ((e_iss && m_occ > 0) ? 1 : 0);
    end
    @(negedge clk);
  endtask

  task automatic tick(input string tag);
    settle(tag);
    adv();
  endtask

  task automatic set_dec(input bit v, input int a, input int b, input bit wa, input bit ub, input bit mc);
    dec_valid = v; dec_a_addr = AW'(a); dec_b_addr = AW'(b);
    dec_writes_a = wa; dec_uses_b = ub; dec_multicycle = mc;
  endtask

  initial begin
    m_occ = 0; m_mode = M_RUN;
`ifdef REG_STATE_SCHED_PERF_EN
    m_stall = 0; m_pushes = 0;
`endif
    clk_en = 1'b1; sync_rst = 1'b1; flush_req = 1'b0;
    cell_dirty = '0; cell_to_be_written = '0;
    issue_valid = 1'b0; issue_a_addr = '0; issue_b_addr = '0; issue_uses_b = 1'b0;
    set_dec(1, 3, 5, 1, 1, 0);
    @(negedge clk);
    // Reset: strobes forced low and counters cleared.
    tick("reset0");
    settle("reset1");
    chk("reset.used_as_a", 32'(used_as_a), 32'h0);
    adv();
    sync_rst = 1'b0;

    // Basic push a=3 write, b=5 read.
    settle("push");
    chk("push.ready", 32'(dec_ready), 32'h1);
    chk("push.ua", 32'(used_as_a), 32'h0008);
    chk("push.ub", 32'(used_as_b), 32'h0020);
    adv();
    settle("push.after");
    chk("push.occ1", 32'(occupancy), 32'h1);
    adv();

    // Read hazard on b=5 stalls, then a one-cycle bubble after it clears.
    m_occ = m_occ; // occupancy advanced by the previous push
    cell_dirty = 16'h0020;
    settle("haz0");
    chk("haz.ready0", 32'(dec_ready), 32'h0);
    adv();
    tick("haz.stall");
    cell_dirty = '0;
    settle("haz.bubble");
    chk("haz.bubble_ready", 32'(dec_ready), 32'h0);
    adv();
    settle("haz.resume");
    chk("haz.resume_ready", 32'(dec_ready), 32'h1);
    adv();

    // Fill the queue, then push+issue at full.
    set_dec(1, 1, 2, 1, 1, 1);
    for (int i = 0; i < 16 && m_occ < QD; i++) tick("fill");
    settle("full");
    chk("full.ready", 32'(dec_ready), 32'h0);
    chk("full.occ", 32'(occupancy), 32'h8);
    adv();
    issue_valid = 1'b1; issue_a_addr = 4'd9; issue_b_addr = 4'd12; issue_uses_b = 1'b1;
    settle("full.pushissue");
    chk("full.pi_ready", 32'(dec_ready), 32'h1);
    adv();
    settle("full.stay8");
    chk("full.stay8_occ", 32'(occupancy), 32'h8);

    // Issue down to 2, then flush with a dirty register.
    dec_valid = 1'b0;
    for (int i = 0; i < 16 && m_occ > 2; i++) tick("issue_down");
    issue_valid = 1'b0; flush_req = 1'b1; cell_dirty = 16'h0080;
    tick("flush.enter");
    issue_valid = 1'b1;
    tick("drain.iss1");
    tick("drain.iss2");
    issue_valid = 1'b0;
    tick("drain.dirty");
    settle("drain.wait");
    chk("drain.not_done", 32'(drained), 32'h0);
    adv();
    cell_dirty = '0;
    tick("drain.clear");
    settle("drained");
    chk("drained.flag", 32'(drained), 32'h1);
    adv();
    flush_req = 1'b0;
    tick("drained.exit");
    set_dec(1, 4, 6, 0, 1, 0);
    settle("run.again");
    chk("run.again_drained", 32'(drained), 32'h0);
    chk("run.again_ready", 32'(dec_ready), 32'h1);
    adv();

    // Clock enable low freezes everything.
    clk_en = 1'b0; issue_valid = 1'b1; issue_a_addr = 4'd2;
    settle("ce0");
    chk("ce0.ua", 32'(used_as_a), 32'h0);
    chk("ce0.ia", 32'(issued_as_a), 32'h0);
    adv();
    settle("ce0.hold");
    chk("ce0.occ", 32'(occupancy), 32'h1);
    adv();
    clk_en = 1'b1; issue_valid = 1'b0;

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) tick("prefill");
    dec_valid = 1'b0; flush_req = 1'b1;
    tick("rstdrain.enter");
    settle("rstdrain.occ4");
    chk("rstdrain.occ4", 32'(occupancy), 32'h4);
    sync_rst = 1'b1;
    adv();
    sync_rst = 1'b0; flush_req = 1'b0;
    settle("rstdrain.after");
    chk("rstdrain.occ0", 32'(occupancy), 32'h0);
    chk("rstdrain.drained0", 32'(drained), 32'h0);
    adv();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      clk_en   = ($urandom_range(0, 7) != 0);
      sync_rst = ($urandom_range(0, 149) == 0);
      set_dec($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) cell_dirty[$urandom_range(0, 15)] = ~cell_dirty[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) cell_dirty = '0;
      cell_to_be_written = ($urandom_range(0, 3) == 0) ? RC'(16'h0001 << $urandom_range(0, 15)) : '0;
      issue_valid  = (m_occ > 0) && ($urandom_range(0, 2) == 0);
      issue_a_addr = AW'($urandom_range(0, 15));
      issue_b_addr = AW'($urandom_range(0, 15));
      issue_uses_b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) flush_req = ~flush_req;
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
